// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus definitions: vector layout and daisy-node source limits.
package z80_bus_pkg;
  localparam int VEC_W       = 8;
  localparam int VBASE_W     = 5;
  localparam int IDX_W       = 2;
  localparam int NUM_SRC_MAX = 4;

  localparam int VEC_BASE_LSB = 3;
  localparam int VEC_IDX_LSB  = 1;

  typedef logic [IDX_W-1:0] src_idx_t;

  // Mode-2 vector: base in [7:3], source index in [2:1], bit 0 always 0.
  function automatic logic [VEC_W-1:0] make_vec(input logic [VBASE_W-1:0] base,
                                                input src_idx_t idx);
    return {base, idx, 1'b0};
  endfunction
endpackage

// File: rtl/z80_daisy_prio.sv
// Lowest-index-wins priority encoder for the local interrupt sources.
module z80_daisy_prio
  import z80_bus_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  output src_idx_t           idx,
  output logic               vld
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = src_idx_t'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/z80_daisy_intc.sv
// Z80 mode-2 daisy-chain interrupt node: latches request edges, arbitrates
// through IEI/IEO, supplies the vector on acknowledge and releases on RETI.
module z80_daisy_intc
  import z80_bus_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic               I_CLK,
  input  logic               I_RESET,
  input  logic               I_CLKEN,
  input  logic [NUM_SRC-1:0] I_REQ,
  input  logic [NUM_SRC-1:0] I_MASK,
  input  logic [4:0]         I_VBASE,
  input  logic               I_IEI,
  input  logic               I_SPM1,
  input  logic               I_RETI,
  output logic               O_INT_n,
  output logic               O_IEO,
  output logic [7:0]         O_VEC,
  output logic               O_VEC_OE
);

  logic [NUM_SRC-1:0] req_q;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] insvc;
  logic [NUM_SRC-1:0] req_edge;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] ack_clr;
  logic               spm1_q;
  logic               ackd;
  logic               ack_go;
  logic               reti_go;
  logic               k_vld;
  src_idx_t           k;

  assign req_edge = I_REQ & ~req_q;
  assign elig     = pend & ~I_MASK;

  z80_daisy_prio #(
    .NUM_SRC (NUM_SRC)
  ) u_prio (
    .req (elig),
    .idx (k),
    .vld (k_vld)
  );

  assign ack_go  = I_SPM1 & ~spm1_q & I_IEI & k_vld & ~|insvc;
  assign reti_go = I_RETI & I_IEI & |insvc;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ack_go && (k == src_idx_t'(i))) ack_clr[i] = 1'b1;
    end
  end

  // Edge history tracks the lines through reset, so a level held across
  // reset is not mistaken for a fresh request or acknowledge.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      req_q   <= I_REQ;
      spm1_q  <= I_SPM1;
      pend    <= '0;
      insvc   <= '0;
      ackd    <= 1'b0;
      O_INT_n <= 1'b1;
      O_VEC   <= '0;
    end else if (I_CLKEN) begin
      req_q   <= I_REQ;
      spm1_q  <= I_SPM1;
      // A new edge on the acknowledged source keeps it pending (re-arm).
      pend    <= (pend & ~ack_clr) | req_edge;
      O_INT_n <= ~(I_IEI & |elig & ~|insvc);
      if (ack_go) begin
        insvc <= ack_clr;
        O_VEC <= make_vec(I_VBASE, k);
      end else if (reti_go) begin
        insvc <= '0;
      end
      if (ack_go)       ackd <= 1'b1;
      else if (!I_SPM1) ackd <= 1'b0;
    end
  end

  assign O_VEC_OE = ackd & I_SPM1;
  assign O_IEO    = I_IEI & ~|insvc & ~|elig;

endmodule

// File: tb/tb_z80_daisy_intc.sv
// Directed self-checking bench for z80_daisy_intc.
module tb_z80_daisy_intc;

  logic       I_CLK = 1'b0;
  logic       I_RESET;
  logic       I_CLKEN;
  logic [3:0] I_REQ;
  logic [3:0] I_MASK;
  logic [4:0] I_VBASE;
  logic       I_IEI;
  logic       I_SPM1;
  logic       I_RETI;
  logic       O_INT_n;
  logic       O_IEO;
  logic [7:0] O_VEC;
  logic       O_VEC_OE;

  int n_cmp = 0;
  int n_bad = 0;

  z80_daisy_intc #(.NUM_SRC(4)) dut (
    .I_CLK    (I_CLK),
    .I_RESET  (I_RESET),
    .I_CLKEN  (I_CLKEN),
    .I_REQ    (I_REQ),
    .I_MASK   (I_MASK),
    .I_VBASE  (I_VBASE),
    .I_IEI    (I_IEI),
    .I_SPM1   (I_SPM1),
    .I_RETI   (I_RETI),
    .O_INT_n  (O_INT_n),
    .O_IEO    (O_IEO),
    .O_VEC    (O_VEC),
    .O_VEC_OE (O_VEC_OE)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic step();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic do_reset();
    I_RESET = 1'b1; I_CLKEN = 1'b1; I_REQ = '0; I_MASK = '0;
    I_IEI = 1'b1; I_SPM1 = 1'b0; I_RETI = 1'b0;
    step();
    I_RESET = 1'b0;
  endtask

  task automatic test_reset();
    I_VBASE = 5'h1A;
    do_reset();
    n_cmp++; if (O_INT_n !== 1'b1) begin n_bad++; $display("FAIL rst_int got=%b exp=1", O_INT_n); end
    n_cmp++; if (O_VEC !== 8'h00) begin n_bad++; $display("FAIL rst_vec got=%h exp=00", O_VEC); end
    n_cmp++; if (O_VEC_OE !== 1'b0) begin n_bad++; $display("FAIL rst_oe got=%b exp=0", O_VEC_OE); end
    n_cmp++; if (O_IEO !== 1'b1) begin n_bad++; $display("FAIL rst_ieo_hi got=%b exp=1", O_IEO); end
    I_IEI = 1'b0; #1;
    n_cmp++; if (O_IEO !== 1'b0) begin n_bad++; $display("FAIL rst_ieo_lo got=%b exp=0", O_IEO); end
    I_IEI = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    I_VBASE = 5'h1A; I_REQ = 4'b0100;
    step();
    n_cmp++; if (O_INT_n !== 1'b1) begin n_bad++; $display("FAIL s2_int_lat1 got=%b exp=1", O_INT_n); end
    n_cmp++; if (O_IEO !== 1'b0) begin n_bad++; $display("FAIL s2_ieo_pend got=%b exp=0", O_IEO); end
    step();
    n_cmp++; if (O_INT_n !== 1'b0) begin n_bad++; $display("FAIL s2_int_low got=%b exp=0", O_INT_n); end
    I_SPM1 = 1'b1;
    step();
    n_cmp++; if (O_VEC !== 8'hD4) begin n_bad++; $display("FAIL s2_vec got=%h exp=d4", O_VEC); end
    n_cmp++; if (O_VEC_OE !== 1'b1) begin n_bad++; $display("FAIL s2_oe got=%b exp=1", O_VEC_OE); end
    step();
    n_cmp++; if (O_INT_n !== 1'b1) begin n_bad++; $display("FAIL s2_int_rel got=%b exp=1", O_INT_n); end
    I_SPM1 = 1'b0; I_REQ = '0;
    step();
    n_cmp++; if (O_VEC_OE !== 1'b0) begin n_bad++; $display("FAIL s2_oe_off got=%b exp=0", O_VEC_OE); end
    n_cmp++; if (O_IEO !== 1'b0) begin n_bad++; $display("FAIL s2_ieo_insvc got=%b exp=0", O_IEO); end
    I_RETI = 1'b1;
    step();
    I_RETI = 1'b0;
    n_cmp++; if (O_IEO !== 1'b1) begin n_bad++; $display("FAIL s2_ieo_reti got=%b exp=1", O_IEO); end
    step();
    n_cmp++; if (O_INT_n !== 1'b1) begin n_bad++; $display("FAIL s2_int_idle got=%b exp=1", O_INT_n); end
  endtask

  task automatic test_priority();
    do_reset();
    I_VBASE = 5'h1A; I_REQ = 4'b1001;
    step(); step();
    n_cmp++; if (O_INT_n !== 1'b0) begin n_bad++; $display("FAIL pr_int1 got=%b exp=0", O_INT_n); end
    I_SPM1 = 1'b1;
    step();
    n_cmp++; if (O_VEC !== 8'hD0) begin n_bad++; $display("FAIL pr_vec0 got=%h exp=d0", O_VEC); end
    I_SPM1 = 1'b0;
    step();
    I_RETI = 1'b1;
    step();
    I_RETI = 1'b0;
    n_cmp++; if (O_INT_n !== 1'b1) begin n_bad++; $display("FAIL pr_int_reti got=%b exp=1", O_INT_n); end
    step();
    n_cmp++; if (O_INT_n !== 1'b0) begin n_bad++; $display("FAIL pr_int2 got=%b exp=0", O_INT_n); end
    I_SPM1 = 1'b1;
    step();
    n_cmp++; if (O_VEC !== 8'hD6) begin n_bad++; $display("FAIL pr_vec3 got=%h exp=d6", O_VEC); end
    n_cmp++; if (O_VEC_OE !== 1'b1) begin n_bad++; $display("FAIL pr_oe3 got=%b exp=1", O_VEC_OE); end
  endtask

  task automatic test_iei_low();
    do_reset();
    I_VBASE = 5'h1A; I_IEI = 1'b0; I_REQ = 4'b0010;
    step(); step(); step();
    n_cmp++; if (O_INT_n !== 1'b1) begin n_bad++; $display("FAIL iei_int got=%b exp=1", O_INT_n); end
    n_cmp++; if (O_IEO !== 1'b0) begin n_bad++; $display("FAIL iei_ieo got=%b exp=0", O_IEO); end
    I_SPM1 = 1'b1;
    step();
    n_cmp++; if (O_VEC_OE !== 1'b0) begin n_bad++; $display("FAIL iei_oe got=%b exp=0", O_VEC_OE); end
    I_SPM1 = 1'b0;
    step();
    I_RETI = 1'b1;
    step();
    I_RETI = 1'b0; I_IEI = 1'b1;
    step();
    n_cmp++; if (O_INT_n !== 1'b0) begin n_bad++; $display("FAIL iei_kept got=%b exp=0", O_INT_n); end
    I_SPM1 = 1'b1;
    step();
    n_cmp++; if (O_VEC !== 8'hD2) begin n_bad++; $display("FAIL iei_vec1 got=%h exp=d2", O_VEC); end
  endtask

  task automatic test_rearm();
    do_reset();
    I_VBASE = 5'h1A; I_REQ = 4'b0010;
    step(); step();
    I_SPM1 = 1'b1;
    step();
    I_SPM1 = 1'b0;
    step();
    I_REQ = '0;
    step();
    I_REQ = 4'b0010;
    step(); step(); step();
    n_cmp++; if (O_INT_n !== 1'b1) begin n_bad++; $display("FAIL ra_noint got=%b exp=1", O_INT_n); end
    I_RETI = 1'b1;
    step();
    I_RETI = 1'b0;
    n_cmp++; if (O_INT_n !== 1'b1) begin n_bad++; $display("FAIL ra_int_at_reti got=%b exp=1", O_INT_n); end
    step();
    n_cmp++; if (O_INT_n !== 1'b0) begin n_bad++; $display("FAIL ra_int_after got=%b exp=0", O_INT_n); end
  endtask

  task automatic test_mask();
    do_reset();
    I_VBASE = 5'h05; I_MASK = 4'b0001; I_REQ = 4'b0101;
    step(); step();
    n_cmp++; if (O_INT_n !== 1'b0) begin n_bad++; $display("FAIL mk_int got=%b exp=0", O_INT_n); end
    I_SPM1 = 1'b1;
    step();
    n_cmp++; if (O_VEC !== 8'h2C) begin n_bad++; $display("FAIL mk_vec got=%h exp=2c", O_VEC); end
    I_SPM1 = 1'b0;
    step();
    I_RETI = 1'b1;
    step();
    I_RETI = 1'b0;
    n_cmp++; if (O_IEO !== 1'b1) begin n_bad++; $display("FAIL mk_ieo got=%b exp=1", O_IEO); end
    step();
    n_cmp++; if (O_INT_n !== 1'b1) begin n_bad++; $display("FAIL mk_int_masked got=%b exp=1", O_INT_n); end
    I_MASK = '0; #1;
    n_cmp++; if (O_IEO !== 1'b0) begin n_bad++; $display("FAIL mk_ieo_unmask got=%b exp=0", O_IEO); end
    step();
    n_cmp++; if (O_INT_n !== 1'b0) begin n_bad++; $display("FAIL mk_int_unmask got=%b exp=0", O_INT_n); end
  endtask

  task automatic test_clken();
    do_reset();
    I_VBASE = 5'h1A; I_CLKEN = 1'b0; I_REQ = 4'b0001;
    step(); step(); step();
    n_cmp++; if (O_INT_n !== 1'b1) begin n_bad++; $display("FAIL ce_int_hold got=%b exp=1", O_INT_n); end
    n_cmp++; if (O_IEO !== 1'b1) begin n_bad++; $display("FAIL ce_ieo_hold got=%b exp=1", O_IEO); end
    I_CLKEN = 1'b1;
    step(); step();
    n_cmp++; if (O_INT_n !== 1'b0) begin n_bad++; $display("FAIL ce_int got=%b exp=0", O_INT_n); end
  endtask

  task automatic test_reset_mid_ack();
    do_reset();
    I_VBASE = 5'h1A; I_REQ = 4'b0001;
    step(); step();
    I_SPM1 = 1'b1;
    step();
    n_cmp++; if (O_VEC_OE !== 1'b1) begin n_bad++; $display("FAIL rm_oe_pre got=%b exp=1", O_VEC_OE); end
    I_RESET = 1'b1;
    step();
    I_RESET = 1'b0;
    n_cmp++; if (O_VEC_OE !== 1'b0) begin n_bad++; $display("FAIL rm_oe got=%b exp=0", O_VEC_OE); end
    n_cmp++; if (O_VEC !== 8'h00) begin n_bad++; $display("FAIL rm_vec got=%h exp=00", O_VEC); end
    n_cmp++; if (O_INT_n !== 1'b1) begin n_bad++; $display("FAIL rm_int got=%b exp=1", O_INT_n); end
    n_cmp++; if (O_IEO !== 1'b1) begin n_bad++; $display("FAIL rm_ieo got=%b exp=1", O_IEO); end
    I_SPM1 = 1'b0;
    step(); step(); step();
    n_cmp++; if (O_INT_n !== 1'b1) begin n_bad++; $display("FAIL rm_no_retrig got=%b exp=1", O_INT_n); end
    n_cmp++; if (O_IEO !== 1'b1) begin n_bad++; $display("FAIL rm_ieo_idle got=%b exp=1", O_IEO); end
    I_REQ = '0;
    step();
    I_REQ = 4'b0001;
    step(); step();
    n_cmp++; if (O_INT_n !== 1'b0) begin n_bad++; $display("FAIL rm_new_edge got=%b exp=0", O_INT_n); end
  endtask

  initial begin
    I_RESET = 1'b1; I_CLKEN = 1'b1; I_REQ = '0; I_MASK = '0; I_VBASE = '0;
    I_IEI = 1'b1; I_SPM1 = 1'b0; I_RETI = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_iei_low();
    test_rearm();
    test_mask();
    test_clken();
    test_reset_mid_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
